// File: rtl/rom_16x4_sync_if.sv
// Read port bundle for rom_16x4_sync: the host drives en/address, the ROM returns data.
// Handshake: en=1 on a rising edge requests mem[address]; there is no ready, the ROM
// always accepts, and data holds that word from the following edge until the next accepted read or reset.
interface rom_16x4_sync_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4
);
    logic              en;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data;

    modport master (
        output en,
        output address,
        input  data
    );

    modport slave (
        input  en,
        input  address,
        output data
    );
endinterface

// File: rtl/rom_16x4_sync.sv
// 16x4 constant lookup table, mem[i] = (7*i + 3) mod 16, with a registered read.
// Define ROM_OUT_PIPE_EN to add a second, always-loading output register (latency 2).
module rom_16x4_sync #(
    parameter int               ADDR_W  = 4,
    parameter int               DATA_W  = 4,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    rom_16x4_sync_if.slave    bus
);

    logic [DATA_W-1:0] rom_word;
    logic [DATA_W-1:0] stage1_q;

    // An address with X/Z bits matches no item in simulation and reads as zero;
    // every real address is listed, so synthesis never reaches the default.
    always_comb begin
        rom_word = '0;
        case (bus.address)
            4'h0: rom_word = 4'h3;
            4'h1: rom_word = 4'hA;
            4'h2: rom_word = 4'h1;
            4'h3: rom_word = 4'h8;
            4'h4: rom_word = 4'hF;
            4'h5: rom_word = 4'h6;
            4'h6: rom_word = 4'hD;
            4'h7: rom_word = 4'h4;
            4'h8: rom_word = 4'hB;
            4'h9: rom_word = 4'h2;
            4'hA: rom_word = 4'h9;
            4'hB: rom_word = 4'h0;
            4'hC: rom_word = 4'h7;
            4'hD: rom_word = 4'hE;
            4'hE: rom_word = 4'h5;
            4'hF: rom_word = 4'hC;
            default: rom_word = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage1_q <= RST_VAL;
        end else if (bus.en) begin
            stage1_q <= rom_word;
        end
    end

`ifdef ROM_OUT_PIPE_EN
    logic [DATA_W-1:0] stage2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stage2_q <= RST_VAL;
        end else begin
            stage2_q <= stage1_q;
        end
    end

    assign bus.data = stage2_q;
`else
    assign bus.data = stage1_q;
`endif

endmodule

// File: tb/tb_rom_16x4_sync.sv
// Self-checking bench for rom_16x4_sync: directed and random reads scored against
// an arithmetic model of the table, with expected words queued by the driver.
module tb_rom_16x4_sync;
    localparam int DATA_W = 4;

    logic clk;
    logic rst;

    rom_16x4_sync_if #(.ADDR_W(4), .DATA_W(DATA_W)) bus ();

    rom_16x4_sync #(.ADDR_W(4), .DATA_W(DATA_W), .RST_VAL(4'h0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // scoreboard state
    logic [DATA_W-1:0] exp_q[$];
    int                n_cmp  = 0;
    int                n_bad  = 0;
    int                cycle  = 0;

    // reference model state: the enabled-read register and the visible output
    logic [DATA_W-1:0] s1_m;
    logic [DATA_W-1:0] out_m;

    function automatic logic [DATA_W-1:0] ref_rom(input logic [3:0] a);
        if ($isunknown(a)) return 4'h0;
        return DATA_W'((7 * int'(a) + 3) % 16);
    endfunction

    // driver: apply one cycle of inputs and queue the word expected after that edge
    task automatic drive(input logic r, input logic e, input logic [3:0] a);
        logic [DATA_W-1:0] s1_next;
        @(negedge clk);
        rst         = r;
        bus.en      = e;
        bus.address = a;
        s1_next = r ? 4'h0 : (e ? ref_rom(a) : s1_m);
`ifdef ROM_OUT_PIPE_EN
        out_m = r ? 4'h0 : s1_m;
`else
        out_m = s1_next;
`endif
        s1_m = s1_next;
        exp_q.push_back(out_m);
    endtask

    // monitor: every edge after the first driven cycle produces one output word
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cycle++;
            if (exp_q.size() > 0) begin
                logic [DATA_W-1:0] e;
                e = exp_q.pop_front();
                n_cmp++;
                if (bus.data !== e) begin
                    n_bad++;
                    $display("FAIL data at cycle %0d: got %h, expected %h", cycle, bus.data, e);
                end
            end
        end
    end

    initial begin
        logic [3:0] xaddr;
        rst         = 1'b0;
        bus.en      = 1'b0;
        bus.address = 4'h0;
        s1_m        = 4'h0;
        out_m       = 4'h0;

        // reset wins over en=1
        drive(1'b1, 1'b1, 4'd5);
        drive(1'b1, 1'b1, 4'd5);
        drive(1'b0, 1'b1, 4'd5);

        // plain back-to-back reads
        drive(1'b0, 1'b1, 4'd12);
        drive(1'b0, 1'b1, 4'd6);
        drive(1'b0, 1'b1, 4'd11);

        // hold with en low while the address moves
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 4'd9);
        drive(1'b0, 1'b0, 4'd3);
        drive(1'b0, 1'b1, 4'd9);
        drive(1'b0, 1'b0, 4'd0);
        drive(1'b0, 1'b0, 4'd0);

        // edge addresses and a full sweep
        drive(1'b0, 1'b1, 4'd0);
        drive(1'b0, 1'b1, 4'd15);
        for (int i = 0; i < 16; i++) drive(1'b0, 1'b1, 4'(i));

        // unknown address
        xaddr = 4'bxxxx;
        drive(1'b0, 1'b1, xaddr);
        drive(1'b0, 1'b0, 4'd1);

        // pipe-depth check: a read followed by holds
        drive(1'b0, 1'b1, 4'd4);
        drive(1'b0, 1'b0, 4'd7);
        drive(1'b0, 1'b0, 4'd7);

        // reset in the middle of a read stream
        drive(1'b0, 1'b1, 4'd13);
        drive(1'b1, 1'b1, 4'd14);
        drive(1'b0, 1'b1, 4'd14);
        drive(1'b0, 1'b1, 4'd2);

        // random traffic
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
                  4'($urandom_range(0, 15)));
        end

        // drain with en low
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 4'($urandom_range(0, 15)));

        repeat (3) @(posedge clk);
        #2;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d words left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
